// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control sequencer.
//   seq_state_t      : sequencer state encoding (also exported on o_state)
//   ST_*             : the same encodings as plain 3-bit constants
//   ADDR_PC/ADDR_DATA: memory address mux select values
//   RD_LAT_MIN/MAX   : legal memory read latency range
//   lat_preload()    : latency counter preload value for a given latency
package cpu_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_FWAIT  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_MWAIT  = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH  = ST_FETCH,
    S_FWAIT  = ST_FWAIT,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_MEM    = ST_MEM,
    S_MWAIT  = ST_MWAIT
  } seq_state_t;

  localparam logic ADDR_PC   = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // The wait states last RD_LAT cycles, so the counter starts at RD_LAT-1.
  // Out-of-range latencies are clamped so the 2-bit counter never wraps.
  function automatic logic [1:0] lat_preload(input int lat);
    int c;
    c = lat;
    if (c < RD_LAT_MIN) c = RD_LAT_MIN;
    if (c > RD_LAT_MAX) c = RD_LAT_MAX;
    return 2'(c - 1);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Shared memory port between the sequencer and the memory.
//   o_mem_rd     : read strobe (sequencer -> memory)
//   o_mem_wr     : write strobe (sequencer -> memory)
//   o_addr_sel   : address mux select, ADDR_PC or ADDR_DATA
//   i_mem_rddata : read data (memory -> sequencer)
//
// Protocol: there is no ready/valid pair on this port. A strobe is a
// single-cycle pulse and is accepted unconditionally in the cycle it is
// high; o_mem_rd and o_mem_wr are never high together. Read data is valid
// exactly RD_LAT cycles after the cycle o_mem_rd was high, and the
// sequencer samples it only in that cycle.
interface cpu_sequencer_if;

  logic        o_mem_rd;
  logic        o_mem_wr;
  logic        o_addr_sel;
  logic [15:0] i_mem_rddata;

  modport master (
    output o_mem_rd,
    output o_mem_wr,
    output o_addr_sel,
    input  i_mem_rddata
  );

  modport slave (
    input  o_mem_rd,
    input  o_mem_wr,
    input  o_addr_sel,
    output i_mem_rddata
  );

endinterface

// File: rtl/seq_lat_counter.sv
// Loadable 2-bit down-counter used to time memory read latency in both
// the instruction-fetch and the data-load wait states.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : preload value
//   dec        : decrement by one; ignored when already zero
//   zero       : count is zero
module seq_lat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != 2'd0)) begin
      count_q <= count_q - 2'd1;
    end
  end

  assign zero = (count_q == 2'd0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer for the 16-bit core. Owns the instruction
// register, steps each instruction through FETCH/FWAIT/DECODE/EXEC and an
// optional MEM/MWAIT phase, drives the shared memory port and turns the
// decoder's combinational outputs into per-cycle enables.
//   clk, reset    : clock, asynchronous active-low reset
//   i_halt        : idle in FETCH while high (sampled only in FETCH)
//   i_is_load     : decoder, instruction reads data memory
//   i_is_store    : decoder, instruction writes data memory (wins over load)
//   i_reg_write   : decoder RegWrite
//   i_nz          : decoder, instruction updates NZ flags
//   i_cnt_load    : debug preload of the retire counter
//   i_cnt_value   : value loaded into the retire counter
//   mem           : shared memory port (master side)
//   o_ir          : instruction register
//   o_pc_en       : PC update enable (once per instruction, in EXEC)
//   o_reg_we      : register-file write enable
//   o_nz_we       : NZ flag write enable
//   o_retired     : one-cycle pulse when an instruction completes
//   o_instr_count : retired instruction count, wraps modulo 2^16
//   o_state       : current state encoding, for debug
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_halt,
  input  logic            i_is_load,
  input  logic            i_is_store,
  input  logic            i_reg_write,
  input  logic            i_nz,
  input  logic            i_cnt_load,
  input  logic [15:0]     i_cnt_value,
  cpu_sequencer_if.master mem,
  output logic [15:0]     o_ir,
  output logic            o_pc_en,
  output logic            o_reg_we,
  output logic            o_nz_we,
  output logic            o_retired,
  output logic [15:0]     o_instr_count,
  output logic [2:0]      o_state
);

  localparam logic [1:0] LAT_LOAD = lat_preload(RD_LAT);

  seq_state_t  state_q;
  seq_state_t  state_d;
  logic        store_q;   // EXEC decision, so MEM ignores later decoder changes
  logic [15:0] ir_q;
  logic [15:0] count_q;

  logic mem_rd;
  logic mem_wr;
  logic addr_sel;
  logic pc_en;
  logic reg_we;
  logic nz_we;
  logic retired;
  logic ir_load;
  logic lat_load;
  logic lat_dec;
  logic lat_zero;

  seq_lat_counter u_lat (
    .clk      (clk),
    .rst_n    (reset),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  always_comb begin
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = ADDR_PC;
    pc_en    = 1'b0;
    reg_we   = 1'b0;
    nz_we    = 1'b0;
    retired  = 1'b0;
    ir_load  = 1'b0;
    lat_load = 1'b0;
    lat_dec  = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!i_halt) begin
          mem_rd   = 1'b1;
          lat_load = 1'b1;
          state_d  = S_FWAIT;
        end
      end

      S_FWAIT: begin
        if (lat_zero) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else begin
          lat_dec = 1'b1;
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        pc_en = 1'b1;
        if (i_is_store || i_is_load) begin
          state_d = S_MEM;
        end else begin
          reg_we  = i_reg_write;
          nz_we   = i_nz;
          retired = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        addr_sel = ADDR_DATA;
        if (store_q) begin
          mem_wr  = 1'b1;
          retired = 1'b1;
          state_d = S_FETCH;
        end else begin
          mem_rd   = 1'b1;
          lat_load = 1'b1;
          state_d  = S_MWAIT;
        end
      end

      S_MWAIT: begin
        addr_sel = ADDR_DATA;
        if (lat_zero) begin
          reg_we  = 1'b1;
          nz_we   = i_nz;
          retired = 1'b1;
          state_d = S_FETCH;
        end else begin
          lat_dec = 1'b1;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      store_q <= 1'b0;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC) begin
        store_q <= i_is_store;
      end
      if (ir_load) begin
        ir_q <= mem.i_mem_rddata;
      end
    end
  end

  // Debug preload wins over the retire increment in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 16'h0000;
    end else if (i_cnt_load) begin
      count_q <= i_cnt_value;
    end else if (retired) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign mem.o_mem_rd   = mem_rd;
  assign mem.o_mem_wr   = mem_wr;
  assign mem.o_addr_sel = addr_sel;

  assign o_ir          = ir_q;
  assign o_pc_en       = pc_en;
  assign o_reg_we      = reg_we;
  assign o_nz_we       = nz_we;
  assign o_retired     = retired;
  assign o_instr_count = count_q;
  assign o_state       = state_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer for the 16-bit processor core. It owns the instruction register and steps each instruction through fetch, decode, execute and an optional memory phase. It drives the single shared memory port and gates the PC, register-file and NZ-flag updates. It sits between the opcode decoder (which consumes `o_ir[4:0]`) and the datapath (PC, GPRs, ALU), and turns their combinational decode into per-cycle enables.

## Interface
- `RD_LAT`, default 1: memory read latency in cycles, from the cycle `o_mem_rd` is asserted to the cycle `i_mem_rddata` is valid. Legal range 1..4.
- `clk` input 1: core clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `i_halt` input 1: when high in FETCH, the core idles without issuing a fetch.
- `i_mem_rddata` input 16: memory read data, valid RD_LAT cycles after a read is issued.
- `i_is_load` input 1: decoder; current instruction reads data memory.
- `i_is_store` input 1: decoder; current instruction writes data memory.
- `i_reg_write` input 1: decoder RegWrite.
- `i_nz` input 1: decoder; instruction updates NZ flags.
- `o_ir` output 16: instruction register.
- `o_mem_rd` output 1: memory read strobe.
- `o_mem_wr` output 1: memory write strobe.
- `o_addr_sel` output 1: memory address mux select; 0 = PC, 1 = data address.
- `o_pc_en` output 1: PC update enable.
- `o_reg_we` output 1: register-file write enable.
- `o_nz_we` output 1: NZ flag write enable.
- `o_retired` output 1: one-cycle pulse when an instruction completes.
- `o_instr_count` output 16: count of retired instructions; wraps modulo 2^16.
- `o_state` output 3: current state encoding, for debug.

## Operation
- **States** (encoding): FETCH=0, FWAIT=1, DECODE=2, EXEC=3, MEM=4, MWAIT=5.
- **FETCH**
  - If `i_halt` is low: `o_mem_rd`=1, `o_addr_sel`=0, load the latency counter with RD_LAT-1, go to FWAIT.
  - If `i_halt` is high: all strobes are 0 and the state stays FETCH.
- **FWAIT**
  - `o_addr_sel`=0.
  - While the counter is nonzero, decrement it and stay.
  - When the counter is 0, `o_ir` <= `i_mem_rddata` at the clock edge, go to DECODE.
- **DECODE**: no strobes; decoder inputs settle from `o_ir`. Go to EXEC.
- **EXEC**: `o_pc_en`=1. The next state depends on the decoder inputs:
  - `i_is_store`=1: go to MEM (write). Store takes priority if both `i_is_store` and `i_is_load` are set.
  - else `i_is_load`=1: go to MEM (read).
  - else: `o_reg_we`=`i_reg_write`, `o_nz_we`=`i_nz`, `o_retired`=1, go to FETCH.
- **MEM** (`o_addr_sel`=1)
  - Store: `o_mem_wr`=1 for exactly this cycle, `o_retired`=1, go to FETCH.
  - Load: `o_mem_rd`=1, load the counter with RD_LAT-1, go to MWAIT.
- **MWAIT** (`o_addr_sel`=1)
  - Count down as in FWAIT.
  - On the counter-0 cycle: `o_reg_we`=1, `o_nz_we`=`i_nz`, `o_retired`=1, go to FETCH.
- **Store/load flag**: a 1-bit flag latched in EXEC selects the MEM behaviour. It is not re-sampled from the decoder in MEM.
- **Output decode**: outputs are combinational from state and the inputs listed above. All strobes are 0 in states not listed as asserting them.
- **`o_instr_count`**: increments on every cycle with `o_retired`=1; 0xFFFF wraps to 0x0000.
- **`i_halt`**: sampled only in FETCH. Assertion mid-instruction has no effect until the next FETCH.

## Timing
- **Reset values**: state FETCH, `o_ir`=0x0000, counter 0, `o_instr_count`=0.
  - With `i_halt` high during reset, all strobes are 0.
  - The first fetch strobe appears in the first cycle after reset deassertion if `i_halt` is low.
- **Reset mid-instruction**: aborts immediately (asynchronous). No pending write is issued and the IR clears.
- **Cycles per instruction**:
  - ALU/branch: 3+RD_LAT.
  - Store: 4+RD_LAT.
  - Load: 4+2·RD_LAT.
- **Memory strobes**:
  - `o_mem_rd` and `o_mem_wr` are never high in the same cycle.
  - Each is a single-cycle pulse per access.
- **Register and PC enables**:
  - `o_reg_we` is high for at most one cycle per instruction.
  - `o_pc_en` is high exactly once per instruction, in EXEC.
- **Halt/retire**: `o_retired` is never asserted while halted.

## Structure
- **Shared package `cpu_pkg`** holds:
  - the `seq_state_t` enum with the encodings above;
  - the `ADDR_PC` / `ADDR_DATA` select constants;
  - the `RD_LAT` legal-range constants.
- **Sub-module `seq_lat_counter`**: a 2-bit loadable down-counter with a zero flag, shared by FWAIT and MWAIT.
- **Top module**: the FSM, the IR register and the retire counter live in `cpu_sequencer`.

## Test plan
- **Reset and first fetch**: hold `reset`=0, then release with `i_halt`=0.
  - Required: cycle 0 has `o_mem_rd`=1, `o_addr_sel`=0, `o_state`=0.
  - Required: with RD_LAT=1 and memory returning 0x1234, `o_ir`=0x1234 when DECODE is entered (cycle 2).
- **ALU instruction** (RD_LAT=1, `i_reg_write`=1, `i_nz`=1, no load/store):
  - Required: `o_pc_en`, `o_reg_we`, `o_nz_we` and `o_retired` all high in cycle 3.
  - Required: next FETCH in cycle 4; `o_instr_count` goes 0→1.
- **Load** (RD_LAT=2):
  - Required: `o_mem_rd` with `o_addr_sel`=1 in MEM.
  - Required: `o_reg_we`=1 exactly 2 cycles later.
  - Required: total 8 cycles between fetch strobes.
- **Store with `i_is_load` also high**:
  - Required: `o_mem_wr`=1 for one cycle in MEM and `o_mem_rd` never asserted in MEM.
  - Required: `o_reg_we`=0 throughout.
- **Halt and wrap**:
  - Required: `i_halt` raised during EXEC still lets the instruction retire.
  - Required: the FSM then stays in FETCH with no strobes until `i_halt` falls.
  - Required: preload the count to 0xFFFF, retire one instruction, and `o_instr_count`=0x0000.
- **Reset during MEM store**: assert `reset` in the MEM cycle.
  - Required: `o_mem_wr` drops immediately, state=FETCH, `o_ir`=0.
